// File: rtl/axis_count_gen.sv
// AXI-Stream counting-pattern source: framed up/down count sequences with
// programmable start, step, frame length and frame count, fully registered outputs.
module axis_count_gen #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned FRM_W  = 16
) (
    input  logic              counter_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              mode,
    input  logic [DATA_W-1:0] count_start,
    input  logic [DATA_W-1:0] count_step,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic [FRM_W-1:0]  num_frames,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              done,
    output logic [FRM_W-1:0]  frame_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t            state;
    logic              mode_r;
    logic [DATA_W-1:0] start_r;
    logic [DATA_W-1:0] step_r;
    logic [LEN_W-1:0]  len_m1_r;
    logic [FRM_W-1:0]  nfrm_r;
    logic [LEN_W-1:0]  beat_idx;
    logic              stop_pend;

    logic [LEN_W-1:0]  len_m1_in;
    logic [LEN_W-1:0]  beat_next;
    logic [FRM_W-1:0]  frm_next;
    logic              last_frame;

    // A zero frame length behaves as a single-beat frame.
    assign len_m1_in  = (frame_len == '0) ? '0 : frame_len - LEN_W'(1);
    assign beat_next  = beat_idx + LEN_W'(1);
    assign frm_next   = frame_cnt + FRM_W'(1);
    assign last_frame = ((nfrm_r != '0) && (frm_next == nfrm_r)) || stop_pend || stop;

    always_ff @(posedge counter_clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            mode_r        <= 1'b0;
            start_r       <= '0;
            step_r        <= '0;
            len_m1_r      <= '0;
            nfrm_r        <= '0;
            beat_idx      <= '0;
            stop_pend     <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state         <= RUN;
                        mode_r        <= mode;
                        start_r       <= count_start;
                        step_r        <= count_step;
                        len_m1_r      <= len_m1_in;
                        nfrm_r        <= num_frames;
                        beat_idx      <= '0;
                        stop_pend     <= 1'b0;
                        m_axis_tdata  <= count_start;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= (len_m1_in == '0);
                        busy          <= 1'b1;
                        frame_cnt     <= '0;
                    end
                end
                RUN: begin
                    if (stop)
                        stop_pend <= 1'b1;
                    if (m_axis_tready) begin
                        if (m_axis_tlast) begin
                            frame_cnt    <= frm_next;
                            beat_idx     <= '0;
                            m_axis_tdata <= start_r;
                            if (last_frame) begin
                                state         <= FIN;
                                m_axis_tvalid <= 1'b0;
                                m_axis_tlast  <= 1'b0;
                                done          <= 1'b1;
                            end else begin
                                m_axis_tlast <= (len_m1_r == '0);
                            end
                        end else begin
                            beat_idx     <= beat_next;
                            m_axis_tdata <= mode_r ? m_axis_tdata - step_r
                                                   : m_axis_tdata + step_r;
                            m_axis_tlast <= (beat_next == len_m1_r);
                        end
                    end
                end
                FIN: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    stop_pend <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_count_gen.sv
// Directed self-checking bench for axis_count_gen: framing, backpressure,
// wrap-around, stop handling, edge cases and mid-run reset.
module tb_axis_count_gen;

    logic        counter_clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic        mode;
    logic [31:0] count_start;
    logic [31:0] count_step;
    logic [15:0] frame_len;
    logic [15:0] num_frames;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        busy;
    logic        done;
    logic [15:0] frame_cnt;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0] got_data[$];
    logic        got_last[$];
    logic [31:0] exp_data[$];
    logic        exp_last[$];

    logic        prev_stall = 1'b0;
    logic [31:0] held_data;
    logic        held_last;

    axis_count_gen #(.DATA_W(32), .LEN_W(16), .FRM_W(16)) dut (
        .counter_clk  (counter_clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .mode         (mode),
        .count_start  (count_start),
        .count_step   (count_step),
        .frame_len    (frame_len),
        .num_frames   (num_frames),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .busy         (busy),
        .done         (done),
        .frame_cnt    (frame_cnt)
    );

    always #5 counter_clk = ~counter_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Capture accepted beats and verify hold-stability under backpressure.
    always @(negedge counter_clk) begin
        if (prev_stall && m_axis_tvalid) begin
            check("hold_data", m_axis_tdata, held_data);
            check("hold_last", m_axis_tlast, held_last);
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        held_data  = m_axis_tdata;
        held_last  = m_axis_tlast;
        if (m_axis_tvalid && m_axis_tready) begin
            got_data.push_back(m_axis_tdata);
            got_last.push_back(m_axis_tlast);
        end
    end

    task automatic start_run(input logic md, input logic [31:0] cs, input logic [31:0] st,
                             input logic [15:0] fl, input logic [15:0] nf, input logic with_stop);
        got_data.delete();
        got_last.delete();
        mode = md; count_start = cs; count_step = st; frame_len = fl; num_frames = nf;
        start = 1'b1;
        stop  = with_stop;
        @(posedge counter_clk); #1;
        start = 1'b0;
        stop  = 1'b0;
        check("start_tvalid", m_axis_tvalid, 1);
        check("start_busy", busy, 1);
        check("start_tdata", m_axis_tdata, cs);
        // Scramble configuration inputs; the running sequence must not react.
        mode = ~md; count_start = 32'h0000_DEAD; count_step = 32'd77;
        frame_len = 16'd9; num_frames = 16'd1;
    endtask

    // pat 0: tready always high; pat 1: alternating plus a 5-cycle low burst.
    task automatic run_to_done(input int pat, input int stop_at, input int busy_start_at,
                               input logic [15:0] exp_frames);
        int  cyc = 0;
        bit  got_done = 0;
        bit  stop_sent = 0;
        while (!got_done && cyc < 400) begin
            if (pat == 0) m_axis_tready = 1'b1;
            else m_axis_tready = ((cyc % 2) == 0) && !(cyc >= 6 && cyc <= 10);
            if (stop_at >= 0 && !stop_sent && got_data.size() == stop_at) begin
                stop = 1'b1;
                stop_sent = 1;
            end else begin
                stop = 1'b0;
            end
            start = (cyc == busy_start_at);
            if (start) count_start = 32'h1234_0000;
            @(posedge counter_clk); #1;
            start = 1'b0;
            stop  = 1'b0;
            cyc++;
            if (done) got_done = 1;
        end
        check("done_seen", got_done, 1);
        check("fin_tvalid", m_axis_tvalid, 0);
        check("fin_busy", busy, 1);
        check("frame_cnt", frame_cnt, exp_frames);
        m_axis_tready = 1'b0;
        @(posedge counter_clk); #1;
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("idle_frame_cnt", frame_cnt, exp_frames);
    endtask

    task automatic compare_seq(input string tag);
        check({tag, "_len"}, got_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
            check($sformatf("%s_last%0d", tag, i), got_last[i], exp_last[i]);
        end
    endtask

    task automatic set_basic_exp();
        exp_data = '{32'd5, 32'd6, 32'd7, 32'd8, 32'd5, 32'd6, 32'd7, 32'd8};
        exp_last = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
        count_start = '0; count_step = '0; frame_len = '0; num_frames = '0;
        m_axis_tready = 1'b0;
        repeat (3) @(posedge counter_clk);
        #1;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        reset = 1'b0;
        @(posedge counter_clk); #1;

        // Stop in IDLE ignored.
        stop = 1'b1;
        @(posedge counter_clk); #1;
        stop = 1'b0;
        check("idle_stop_busy", busy, 0);

        // Basic frames; stop together with start must be ignored.
        start_run(1'b0, 32'd5, 32'd1, 16'd4, 16'd2, 1'b1);
        run_to_done(0, -1, -1, 16'd2);
        set_basic_exp();
        compare_seq("basic");

        // Backpressure plus a start while busy.
        start_run(1'b0, 32'd5, 32'd1, 16'd4, 16'd2, 1'b0);
        run_to_done(1, -1, 3, 16'd2);
        set_basic_exp();
        compare_seq("bp");

        // Down-count with wrap.
        start_run(1'b1, 32'd2, 32'd3, 16'd3, 16'd1, 1'b0);
        run_to_done(0, -1, -1, 16'd1);
        exp_data = '{32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
        exp_last = '{1'b0, 1'b0, 1'b1};
        compare_seq("down");

        // Continuous run; stop during beat 2 of frame 3 (handshake index 11).
        start_run(1'b0, 32'd100, 32'd10, 16'd5, 16'd0, 1'b0);
        run_to_done(0, 11, -1, 16'd3);
        exp_data.delete();
        exp_last.delete();
        for (int f = 0; f < 3; f++)
            for (int b = 0; b < 5; b++) begin
                exp_data.push_back(32'd100 + 32'(10 * b));
                exp_last.push_back(b == 4);
            end
        compare_seq("stop");

        // frame_len = 0 acts as single-beat frames.
        start_run(1'b0, 32'd7, 32'd1, 16'd0, 16'd3, 1'b0);
        run_to_done(0, -1, -1, 16'd3);
        exp_data = '{32'd7, 32'd7, 32'd7};
        exp_last = '{1'b1, 1'b1, 1'b1};
        compare_seq("len0");

        // Reset during beat 2 of frame 1, then a fresh run.
        start_run(1'b0, 32'd5, 32'd1, 16'd4, 16'd2, 1'b0);
        m_axis_tready = 1'b1;
        @(posedge counter_clk); #1;
        check("pre_rst_tdata", m_axis_tdata, 32'd6);
        reset = 1'b1;
        #1;
        check("mid_rst_tvalid", m_axis_tvalid, 0);
        check("mid_rst_tlast", m_axis_tlast, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_tdata", m_axis_tdata, 0);
        check("mid_rst_frame_cnt", frame_cnt, 0);
        @(posedge counter_clk); #1;
        check("mid_rst_hold", m_axis_tvalid, 0);
        reset = 1'b0;
        m_axis_tready = 1'b0;
        @(posedge counter_clk); #1;
        start_run(1'b0, 32'd5, 32'd1, 16'd4, 16'd2, 1'b0);
        run_to_done(0, -1, -1, 16'd2);
        set_basic_exp();
        compare_seq("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axis_count_gen.md
# axis_count_gen

Parametrised AXI-Stream counting-pattern source for the Axis_fifo test environment. It generates framed up or down count sequences with a programmable start value, step, frame length and frame count. It holds a fully AXI-compliant master handshake: data is held under backpressure and TLAST marks frame ends. It sits upstream of the AXI-Stream FIFO as stimulus and throughput source.

## Interface
Parameters:
- DATA_W, 32: width of tdata and of the count arithmetic.
- LEN_W, 16: width of the frame-length (beat) counter.
- FRM_W, 16: width of the frame counter.

Ports:
- counter_clk  in  1  clock; all logic on its rising edge.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to begin a run; ignored while busy=1.
- stop  in  1  graceful stop request; ends the run after the current frame.
- mode  in  1  0 = count up, 1 = count down.
- count_start  in  DATA_W  first value of every frame.
- count_step  in  DATA_W  increment or decrement per beat.
- frame_len  in  LEN_W  beats per frame; 0 is treated as 1.
- num_frames  in  FRM_W  frames per run; 0 = continuous until stop.
- m_axis_tdata  out  DATA_W  current count value.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of a frame.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse when a run ends.
- frame_cnt  out  FRM_W  frames completed in the current or last run.

## Operation
- FSM states are IDLE, RUN and FIN.
  - IDLE -> RUN when start=1. mode, count_start, count_step, frame_len and num_frames are latched into internal registers; later changes to these inputs have no effect until the next start.
  - RUN -> FIN on the handshake (tvalid&tready) of a tlast beat when either of these holds: frame_cnt+1 == num_frames with num_frames != 0, or a stop is pending.
  - FIN -> IDLE unconditionally after 1 cycle.
- Handshake: tvalid=1 throughout RUN. tdata and tlast change only on a handshake cycle. While tvalid=1 and tready=0, both are held stable.
- Beat index: increments on each handshake and clears to 0 on a tlast handshake. tlast = (beat index == effective frame_len-1).
- Data:
  - First beat of each frame = latched count_start.
  - Each non-last handshake loads tdata ± count_step, modulo 2^DATA_W. Wrap-around is silent, no saturation.
  - A tlast handshake reloads count_start.
- stop:
  - A stop in RUN sets a sticky pending flag, cleared on entry to IDLE.
  - If stop coincides with a tlast handshake, that frame is the final one.
  - stop in IDLE is ignored.
- frame_cnt: cleared on start acceptance and incremented on each tlast handshake. It holds its value in IDLE.
- start and stop asserted together in IDLE: start is accepted and stop is ignored.
- frame_len=1: every beat has tlast=1 and tdata=count_start.

## Timing
- Reset values (applied asynchronously): tvalid=0, tlast=0, tdata=0, busy=0, done=0, frame_cnt=0, FSM=IDLE, stop pending cleared.
- Reset mid-run: tvalid drops immediately with no frame completion. The downstream sees a truncated frame.
- Latency: start sampled at edge N gives tvalid=1, busy=1 and tdata=count_start after edge N.
- Throughput: 1 beat per cycle with tready held high. There are no bubbles between frames.
- End of run: the final tlast handshake at edge M gives tvalid=0 and done=1 after M (FIN). After M+1, done=0, busy=0 and the FSM is in IDLE. A new start is accepted from edge M+1.
- tready is not used combinationally toward any output; all outputs are registered.

## Test plan
- Basic frames: DATA_W=32, mode=0, count_start=5, count_step=1, frame_len=4, num_frames=2, tready=1. Expect tdata 5,6,7,8,5,6,7,8 with tlast on beats 4 and 8, done one cycle after beat 8, frame_cnt=2.
- Backpressure: same setup, tready toggling 1010… plus a 5-cycle low burst. tdata and tlast must be held stable while tready=0. The sequence is identical to the basic-frames case with no drops or duplicates.
- Down-count with wrap: mode=1, count_start=2, count_step=3, frame_len=3, num_frames=1. Expect tdata 2, 0xFFFFFFFF, 0xFFFFFFFC, tlast on the third beat.
- Continuous run with stop: num_frames=0, frame_len=5. Pulse stop during beat 2 of frame 3. Frame 3 completes all 5 beats, then done fires and frame_cnt=3.
- Edge cases:
  - frame_len=0: every beat has tlast=1.
  - start while busy: ignored.
  - Inputs changed during the run: no effect.
- Reset mid-run: assert reset during beat 2 of frame 1. tvalid and tlast go to 0 immediately and all reset values hold. A new start after reset release yields a fresh sequence from count_start.
